sw_logic_unit: RTL and testbench



---
 rtl/sw_logic_pkg.sv | 29 ++
 rtl/debounce.sv | 39 +++
 rtl/sw_logic_unit.sv | 111 +++++++++++
 tb/tb_sw_logic_unit.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_logic_pkg.sv
// rtl/sw_logic_pkg.sv - operation codes and bitwise operation helpers for sw_logic_unit
package sw_logic_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_NAND = 2'd3
  } op_t;

  // One result bit of the selected operation between operand bits a and b
  function automatic logic apply_op(op_t op, logic a, logic b);
    logic r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Mode sequence wraps OP_NAND back to OP_AND
  function automatic op_t next_op(op_t op);
    return op_t'(op + 2'd1);
  endfunction

endpackage

// File: rtl/debounce.sv
// rtl/debounce.sv - single-bit 2-flop synchroniser followed by a stability-count debouncer
module debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt;

  // Synchronise the raw input, then only accept a new level once it has differed from stable for DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      cnt     <= '0;
      stable  <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      if (sync_q2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync_q2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sw_logic_unit.sv
// rtl/sw_logic_unit.sv - debounced switch-half logic unit with button-stepped mode (optional MODE_AUTO_EN auto-step)
module sw_logic_unit
  import sw_logic_pkg::*;
#(
  parameter int NUM_SW          = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int AUTO_CYCLES     = 100000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_SW-1:0]   SW,
  input  logic                BTN,
  output logic [NUM_SW/2-1:0] LED,
  output logic [1:0]          MODE,
  output logic                CHG
);

  localparam int H = NUM_SW / 2;

  logic [NUM_SW:0] raw_in;
  logic [NUM_SW:0] db;
  logic [H-1:0]    op_a;
  logic [H-1:0]    op_b;
  logic            btn_db;
  logic            btn_prev;
  logic            btn_step;
  logic            mode_step;
  op_t             mode_q;
  logic [H-1:0]    led_next;

  // Button rides as the top bit so every input shares one debouncer array
  assign raw_in = {BTN, SW};

  for (genvar i = 0; i <= NUM_SW; i++) begin : g_db
    debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw_in[i]),
      .stable(db[i])
    );
  end

  assign op_a     = db[H-1:0];
  assign op_b     = db[NUM_SW-1:H];
  assign btn_db   = db[NUM_SW];
  assign btn_step = btn_db & ~btn_prev;

`ifdef MODE_AUTO_EN
  localparam int AW = $clog2(AUTO_CYCLES);
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_CYCLES - 1);

  logic [AW-1:0] auto_cnt;
  logic          auto_step;

  assign auto_step = (auto_cnt == AUTO_LAST);
  // Coinciding button and auto steps collapse into one advance
  assign mode_step = btn_step | auto_step;

  // Free-running period counter, restarted by any mode advance so a button press begins a fresh period
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      auto_cnt <= '0;
    end else if (btn_step || auto_step) begin
      auto_cnt <= '0;
    end else begin
      auto_cnt <= auto_cnt + 1'b1;
    end
  end
`else
  localparam int unused_auto_cycles = AUTO_CYCLES;

  assign mode_step = btn_step;
`endif

  // Mode FSM: one step per debounced button rising edge, holding the button does not repeat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q   <= OP_AND;
      btn_prev <= 1'b0;
    end else begin
      btn_prev <= btn_db;
      if (mode_step) begin
        mode_q <= next_op(mode_q);
      end
    end
  end

  assign MODE = mode_q;

  // Bitwise operation of the lower and upper switch halves under the current mode
  always_comb begin
    led_next = '0;
    for (int i = 0; i < H; i++) begin
      led_next[i] = apply_op(mode_q, op_a[i], op_b[i]);
    end
  end

  // LED register and change pulse aligned with the cycle the new LED value appears
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      LED <= '0;
      CHG <= 1'b0;
    end else begin
      LED <= led_next;
      CHG <= (led_next != LED);
    end
  end

endmodule

// File: tb/tb_sw_logic_unit.sv
// tb/tb_sw_logic_unit.sv - self-checking scoreboard bench for sw_logic_unit
module tb_sw_logic_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] SW;
  logic       BTN;
  logic [1:0] LED;
  logic [1:0] MODE;
  logic       CHG;

  int checks = 0;
  int errors = 0;

  logic [1:0] exp_q[$];
  logic [1:0] exp_cur;
  logic [1:0] mode_m;
  logic [3:0] sw_m;
  bit         mon_en = 1'b0;
  logic [1:0] mon_prev;
  logic [1:0] mon_e;

  always #5 clk = ~clk;

  sw_logic_unit #(
    .NUM_SW(4),
    .DEBOUNCE_CYCLES(4),
    .AUTO_CYCLES(20)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .SW   (SW),
    .BTN  (BTN),
    .LED  (LED),
    .MODE (MODE),
    .CHG  (CHG)
  );

  function automatic logic [1:0] model_led(logic [1:0] m, logic [3:0] s);
    logic [1:0] a;
    logic [1:0] b;
    a = s[1:0];
    b = s[3:2];
    case (m)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_if_changed();
    logic [1:0] e;
    e = model_led(mode_m, sw_m);
    if (e !== exp_cur) begin
      exp_q.push_back(e);
      exp_cur = e;
    end
  endtask

  task automatic set_sw(input logic [3:0] v);
    SW   = v;
    sw_m = v;
    push_if_changed();
  endtask

  task automatic press(input int hold, input int gap);
    logic [1:0] old_mode;
    old_mode = mode_m;
    BTN    = 1'b1;
    mode_m = mode_m + 2'd1;
    push_if_changed();
    tick(6);
    checks++;
    if (MODE !== old_mode) begin
      errors++;
      $display("FAIL press_mode_early: MODE=%0d expected %0d", MODE, old_mode);
    end
    tick(1);
    checks++;
    if (MODE !== mode_m) begin
      errors++;
      $display("FAIL press_mode_latency: MODE=%0d expected %0d", MODE, mode_m);
    end
    tick(hold - 7);
    BTN = 1'b0;
    tick(gap);
  endtask

  // Scoreboard: every CHG pulse pops the next expected LED value
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      checks++;
      if (CHG !== (LED !== mon_prev)) begin
        errors++;
        $display("FAIL chg_vs_led: CHG=%b LED=%b prev LED=%b", CHG, LED, mon_prev);
      end
      if (CHG === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: LED=%b with no expected change queued", LED);
        end else begin
          mon_e = exp_q.pop_front();
          if (LED !== mon_e) begin
            errors++;
            $display("FAIL sb_led: LED=%b expected %b", LED, mon_e);
          end
        end
      end
      mon_prev = LED;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    SW    = 4'hF;
    BTN   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checks++;
      if (LED !== 2'b00 || MODE !== 2'd0 || CHG !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: LED=%b MODE=%0d CHG=%b expected 00/0/0", LED, MODE, CHG);
      end
    end
    exp_q.delete();
    mode_m  = 2'd0;
    sw_m    = 4'hF;
    exp_cur = 2'b00;
    rst_n   = 1'b1;
    mon_prev = LED;
    mon_en   = 1'b1;
    push_if_changed();
    tick(1);
    checks++;
    if (LED !== 2'b00 || MODE !== 2'd0 || CHG !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: LED=%b MODE=%0d CHG=%b expected 00/0/0", LED, MODE, CHG);
    end
    tick(20);
  endtask

  task automatic test_sweep();
    logic [1:0] old_led;
    logic [1:0] new_led;
    for (int v = 0; v < 16; v++) begin
      old_led = exp_cur;
      new_led = model_led(mode_m, 4'(v));
      set_sw(4'(v));
      tick(6);
      checks++;
      if (LED !== old_led) begin
        errors++;
        $display("FAIL sweep_early sw=%h: LED=%b expected %b", v, LED, old_led);
      end
      tick(1);
      checks++;
      if (LED !== new_led) begin
        errors++;
        $display("FAIL sweep_latency sw=%h: LED=%b expected %b", v, LED, new_led);
      end
      tick(13);
    end
  endtask

  task automatic test_glitch();
    set_sw(4'b1110);
    tick(20);
    SW = 4'b1111;
    tick(3);
    SW = 4'b1110;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      checks++;
      if (CHG !== 1'b0) begin
        errors++;
        $display("FAIL glitch_chg: CHG=%b expected 0", CHG);
      end
    end
    checks++;
    if (LED !== 2'b10) begin
      errors++;
      $display("FAIL glitch_led: LED=%b expected 10", LED);
    end
  endtask

  task automatic test_mode_cycle();
    logic [1:0] exp_mode [5];
    logic [1:0] exp_led  [5];
    exp_mode = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    exp_led  = '{2'b11, 2'b11, 2'b11, 2'b00, 2'b11};
    set_sw(4'b0110);
    tick(20);
    for (int k = 0; k < 5; k++) begin
      press(10, 10);
      checks++;
      if (MODE !== exp_mode[k] || LED !== exp_led[k]) begin
        errors++;
        $display("FAIL mode_cycle press %0d: MODE=%0d LED=%b expected %0d/%b",
                 k, MODE, LED, exp_mode[k], exp_led[k]);
      end
    end
  endtask

  task automatic test_button_hold();
    press(100, 20);
    checks++;
    if (MODE !== 2'd2) begin
      errors++;
      $display("FAIL button_hold: MODE=%0d expected 2", MODE);
    end
    BTN = 1'b1;
    tick(2);
    BTN = 1'b0;
    tick(20);
    checks++;
    if (MODE !== 2'd2) begin
      errors++;
      $display("FAIL button_bounce: MODE=%0d expected 2", MODE);
    end
  endtask

  task automatic test_reset_mid_debounce();
    set_sw(4'b0000);
    tick(20);
    SW = 4'hF;
    tick(3);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    tick(2);
    checks++;
    if (LED !== 2'b00 || MODE !== 2'd0 || CHG !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_state: LED=%b MODE=%0d CHG=%b expected 00/0/0", LED, MODE, CHG);
    end
    exp_q.delete();
    mode_m   = 2'd0;
    sw_m     = 4'hF;
    exp_cur  = 2'b00;
    rst_n    = 1'b1;
    mon_prev = LED;
`ifndef MODE_AUTO_EN
    mon_en   = 1'b1;
`endif
    push_if_changed();
    for (int i = 0; i < 6; i++) begin
      tick(1);
      checks++;
      if (LED !== 2'b00) begin
        errors++;
        $display("FAIL mid_reset_requalify cycle %0d: LED=%b expected 00", i + 1, LED);
      end
    end
    tick(1);
    checks++;
    if (LED !== 2'b11) begin
      errors++;
      $display("FAIL mid_reset_latency: LED=%b expected 11", LED);
    end
`ifdef MODE_AUTO_EN
    tick(38);
    checks++;
    if (MODE !== 2'd2) begin
      errors++;
      $display("FAIL auto_mode: MODE=%0d expected 2", MODE);
    end
    exp_q.delete();
`else
    tick(10);
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d expected changes never seen, expected 0", exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    SW    = 4'h0;
    BTN   = 1'b0;
    test_reset();
    test_sweep();
    test_glitch();
    test_mode_cycle();
    test_button_hold();
    test_reset_mid_debounce();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
